truth_table_sweeper: RTL and testbench

//  Sequencer for 3-input truth-table logic blocks, e.g. m0x3B. It drives in1/in2/in3

---
 rtl/truth_table_sweeper_if.sv | 35 +++
 rtl/truth_table_sweeper.sv | 124 ++++++++++++
 tb/tb_truth_table_sweeper.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_sweeper_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : truth_table_sweeper_if                                            |
// | Desc   : Control/result and logic-block signals of the truth-table sweeper |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
interface truth_table_sweeper_if #(
  parameter int SETTLE_W = 8
);
  logic                start;
  logic [7:0]          expected;
  logic [SETTLE_W-1:0] settle_cycles;
  logic                dut_out;
  logic                in1;
  logic                in2;
  logic                in3;
  logic                busy;
  logic                done;
  logic                pass;
  logic [7:0]          captured;
  logic [7:0]          mismatch;
  logic [2:0]          fail_idx;

  // Controller side: issues sweeps and also hosts the swept logic block.
  modport master (
    output start, expected, settle_cycles, dut_out,
    input  in1, in2, in3, busy, done, pass, captured, mismatch, fail_idx
  );

  modport slave (
    input  start, expected, settle_cycles, dut_out,
    output in1, in2, in3, busy, done, pass, captured, mismatch, fail_idx
  );
endinterface
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : truth_table_sweeper                                               |
// | Desc   : Drives all 8 vectors into a 3-input block, builds its function    |
// |          code and compares it with an expected code.                       |
// |          Optional macro SWEEP_ABORT_EN: stop at the first wrong sample.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module truth_table_sweeper #(
  parameter int SETTLE_W = 8
) (
  input  wire logic clk,
  input  wire logic rst_n,
  truth_table_sweeper_if.slave sw
);

  localparam logic [1:0]          c_st_idle = 2'd0;
  localparam logic [1:0]          c_st_run  = 2'd1;
  localparam logic [1:0]          c_st_done = 2'd2;
  localparam logic [SETTLE_W-1:0] c_one     = 1;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [2:0]          r_idx;
  logic [SETTLE_W-1:0] r_cnt;
  logic [SETTLE_W-1:0] r_settle;
  logic [7:0]          r_exp;
  logic [7:0]          r_cap;
  logic [7:0]          r_mism;
  logic                r_pass;
  logic [2:0]          r_fidx;

  logic                w_sample;
  logic                w_abort;
  logic                w_last;
  logic [7:0]          w_cap_nxt;
  logic [7:0]          w_mask;
  logic [7:0]          w_mism_nxt;

  // Lowest sweep index whose bit is set; bit 7 corresponds to idx 0.
  function automatic logic [2:0] first_set(input logic [7:0] m);
    logic [2:0] f;
    f = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[7-i]) f = 3'(i);
    end
    return f;
  endfunction

  assign w_sample   = (r_state == c_st_run) && (r_cnt == '0);
  assign w_cap_nxt  = r_cap | ({7'd0, sw.dut_out} << (3'd7 - r_idx));
  // Only bits sampled so far take part in the comparison.
  assign w_mask     = 8'hFF << (3'd7 - r_idx);
  assign w_mism_nxt = (w_cap_nxt ^ r_exp) & w_mask;

`ifdef SWEEP_ABORT_EN
  assign w_abort = sw.dut_out != r_exp[3'd7 - r_idx];
`else
  assign w_abort = 1'b0;
`endif

  assign w_last = w_sample && ((r_idx == 3'd7) || w_abort);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_st_idle;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (sw.start) w_state_nxt = c_st_run;
      c_st_run:  if (w_last)   w_state_nxt = c_st_done;
      c_st_done: w_state_nxt = c_st_idle;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    sw.busy                  = (r_state == c_st_run);
    sw.done                  = (r_state == c_st_done);
    {sw.in1, sw.in2, sw.in3} = (r_state == c_st_run) ? r_idx : 3'd0;
    sw.pass                  = r_pass;
    sw.captured              = r_cap;
    sw.mismatch              = r_mism;
    sw.fail_idx              = r_fidx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= 3'd0;
      r_cnt    <= '0;
      r_settle <= '0;
      r_exp    <= 8'd0;
      r_cap    <= 8'd0;
      r_mism   <= 8'd0;
      r_pass   <= 1'b0;
      r_fidx   <= 3'd0;
    end else if ((r_state == c_st_idle) && sw.start) begin
      r_idx    <= 3'd0;
      r_cnt    <= sw.settle_cycles;
      r_settle <= sw.settle_cycles;
      r_exp    <= sw.expected;
      r_cap    <= 8'd0;
    end else if (r_state == c_st_run) begin
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - c_one;
      end else begin
        r_cap <= w_cap_nxt;
        if (w_last) begin
          r_mism <= w_mism_nxt;
          r_pass <= (w_mism_nxt == 8'd0);
          r_fidx <= first_set(w_mism_nxt);
          r_idx  <= 3'd0;
        end else begin
          r_idx <= r_idx + 3'd1;
          r_cnt <= r_settle;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_truth_table_sweeper                                            |
// | Desc   : Cycle-level reference model plus directed and random sweeps       |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_truth_table_sweeper;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  truth_table_sweeper_if #(.SETTLE_W(8)) bus ();

  // Swept logic block: a 3-input function given by its code.
  logic [7:0] blk = 8'h00;
  assign bus.dut_out = blk[3'd7 - {bus.in1, bus.in2, bus.in3}];

  truth_table_sweeper #(.SETTLE_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] top(input int n);
    if (n <= 0) return 8'h00;
    if (n >= 8) return 8'hFF;
    return 8'(8'hFF << (8 - n));
  endfunction

  // Reference model: time since the accepted start edge decides everything.
  logic [7:0] m_F, m_E, m_cap, m_mism, p_mism;
  logic [2:0] m_fidx, p_fidx;
  bit         m_busy, m_done, m_pass, p_pass;
  int         m_S, m_t, m_L, m_fd, m_n;

  initial begin
    {m_F, m_E, m_cap, m_mism, p_mism} = '0;
    {m_fidx, p_fidx} = '0;
    {m_busy, m_done, m_pass, p_pass} = '0;
    {m_S, m_t, m_L, m_fd, m_n} = '0;
  end

  always begin
    @(posedge clk);
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_pass = 0;
      m_cap = 0;  m_mism = 0; m_fidx = 0;
    end else if (m_busy) begin
      m_t++;
      m_cap = m_F & top(m_t / (m_S + 1));
      if (m_t == m_L) begin
        m_busy = 0; m_done = 1;
        m_mism = p_mism; m_pass = p_pass; m_fidx = p_fidx;
      end
    end else if (m_done) begin
      m_done = 0;
    end else if (bus.start) begin
      m_F = blk; m_E = bus.expected; m_S = int'(bus.settle_cycles);
      m_t = 0; m_busy = 1; m_cap = 0;
      m_fd = 8;
      for (int i = 0; i < 8; i++)
        if (m_fd == 8 && m_F[7-i] != m_E[7-i]) m_fd = i;
      m_n = 8;
`ifdef SWEEP_ABORT_EN
      if (m_fd < 8) m_n = m_fd + 1;
`endif
      m_L    = m_n * (m_S + 1);
      p_mism = (m_F ^ m_E) & top(m_n);
      p_pass = (p_mism == 8'h00);
      p_fidx = (m_fd < 8) ? 3'(m_fd) : 3'd0;
    end
    #1;
    chk("vector",   32'({bus.in1, bus.in2, bus.in3}), 32'(m_busy ? 3'(m_t / (m_S + 1)) : 3'd0));
    chk("busy",     32'(bus.busy),     32'(m_busy));
    chk("done",     32'(bus.done),     32'(m_done));
    chk("captured", 32'(bus.captured), 32'(m_cap));
    chk("pass",     32'(bus.pass),     32'(m_pass));
    chk("mismatch", 32'(bus.mismatch), 32'(m_mism));
    chk("fail_idx", 32'(bus.fail_idx), 32'(m_fidx));
  end

  // lat: cycles from the accepted start edge to done; bcnt: cycles busy was high.
  task automatic run_sweep(input logic [7:0] f, input logic [7:0] e, input int s,
                           input int poke_at, input int rst_at, input bit start_in_done,
                           output int lat, output int bcnt, output bit got_done);
    int limit;
    @(negedge clk);
    blk = f; bus.expected = e; bus.settle_cycles = 8'(s); bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0; bcnt = int'(bus.busy); got_done = 0;
    limit = 8 * (s + 1) + 4;
    while (!got_done && lat < limit) begin
      bus.start         = (lat == poke_at - 1);
      bus.expected      = 8'($urandom);
      bus.settle_cycles = 8'($urandom);
      @(posedge clk); #1;
      lat++;
      if (lat == rst_at) begin
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset", 32'({bus.in1, bus.in2, bus.in3, bus.busy, bus.done, bus.pass,
                                bus.captured, bus.mismatch, bus.fail_idx}), 32'd0);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        break;
      end
      bcnt += int'(bus.busy);
      got_done = bus.done;
    end
    bus.start = start_in_done;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  int lat, bcnt;
  bit gd;
  logic [7:0] rf, re;
  int rs;

  initial begin
    bus.start = 1'b0; bus.expected = 8'h00; bus.settle_cycles = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // m0x3B, matching expectation, one clock per vector.
    run_sweep(8'h3B, 8'h3B, 0, -1, -1, 0, lat, bcnt, gd);
    chk("t1_done", 32'(gd), 32'd1);
    chk("t1_lat", 32'(lat), 32'd8);
    chk("t1_busy_cycles", 32'(bcnt), 32'd8);
    chk("t1_pass", 32'(bus.pass), 32'd1);
    chk("t1_captured", 32'(bus.captured), 32'h3B);
    chk("t1_mismatch", 32'(bus.mismatch), 32'h00);
    chk("t1_fail_idx", 32'(bus.fail_idx), 32'd0);

    // Wrong expectation in the last bit.
    run_sweep(8'h3B, 8'h3A, 0, -1, -1, 0, lat, bcnt, gd);
    chk("t2_pass", 32'(bus.pass), 32'd0);
`ifdef SWEEP_ABORT_EN
    chk("t2_lat", 32'(lat), 32'd8);
`endif
    chk("t2_mismatch", 32'(bus.mismatch), 32'h01);
    chk("t2_fail_idx", 32'(bus.fail_idx), 32'd7);
    chk("t2_captured", 32'(bus.captured), 32'h3B);

    // Four-cycle hold per vector.
    run_sweep(8'h3B, 8'h3B, 3, -1, -1, 0, lat, bcnt, gd);
    chk("t3_lat", 32'(lat), 32'd32);
    chk("t3_busy_cycles", 32'(bcnt), 32'd32);

    // Start poked mid-sweep and again in DONE: both ignored.
    run_sweep(8'h3B, 8'h3B, 3, 5, -1, 1, lat, bcnt, gd);
    chk("t4_lat", 32'(lat), 32'd32);
    repeat (5) @(posedge clk);
    #1;
    chk("t4_held_pass", 32'(bus.pass), 32'd1);
    chk("t4_held_captured", 32'(bus.captured), 32'h3B);
    run_sweep(8'h96, 8'h96, 1, -1, -1, 0, lat, bcnt, gd);
    chk("t4_restart_lat", 32'(lat), 32'd16);
    chk("t4_restart_captured", 32'(bus.captured), 32'h96);

    // Reset in the middle of a sweep, then a clean sweep.
    run_sweep(8'h3B, 8'h3B, 3, -1, 10, 0, lat, bcnt, gd);
    chk("t5_no_done", 32'(gd), 32'd0);
    run_sweep(8'h3B, 8'h3B, 0, -1, -1, 0, lat, bcnt, gd);
    chk("t5_after_pass", 32'(bus.pass), 32'd1);

    // First vector wrong.
    run_sweep(8'h3B, 8'hBB, 0, -1, -1, 0, lat, bcnt, gd);
    chk("t6_mismatch", 32'(bus.mismatch), 32'h80);
    chk("t6_fail_idx", 32'(bus.fail_idx), 32'd0);
    chk("t6_pass", 32'(bus.pass), 32'd0);
`ifdef SWEEP_ABORT_EN
    chk("t6_lat", 32'(lat), 32'd1);
    chk("t6_captured", 32'(bus.captured), 32'h00);
`else
    chk("t6_lat", 32'(lat), 32'd8);
    chk("t6_captured", 32'(bus.captured), 32'h3B);
`endif

    // Longest hold: counter must count the full range.
    run_sweep(8'hE8, 8'hE8, 255, -1, -1, 0, lat, bcnt, gd);
    chk("smax_lat", 32'(lat), 32'd2048);

    for (int n = 0; n < 40; n++) begin
      rf = 8'($urandom);
      case ($urandom_range(0, 2))
        0:       re = rf;
        1:       re = rf ^ (8'h01 << $urandom_range(0, 7));
        default: re = 8'($urandom);
      endcase
      rs = $urandom_range(0, 4);
      run_sweep(rf, re, rs, $urandom_range(0, 8 * (rs + 1)), -1, 1'($urandom),
                lat, bcnt, gd);
      chk("rand_done", 32'(gd), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
